// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and helpers for the M-stage data-memory access controller.
// Optional feature macro: DMEM_TIMEOUT_EN (watchdog abort of stuck bus accesses).
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // An access is misaligned when its address is not a multiple of its size.
  // Size code 3 has no legal meaning, so it is always rejected here.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the M-stage access controller and the memory.
// Optional feature macro: DMEM_TIMEOUT_EN (not used in this file).
//
// Handshake: a request transfers in the cycle where dmem_req && dmem_ready.
// The master holds dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_size
// stable from the cycle it raises dmem_req until that transfer. For a load,
// dmem_rdata is valid in the cycle where dmem_rvalid is high; the master only
// consumes it while it is waiting for load data and ignores it otherwise.
interface dmem_bus_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [1:0]  dmem_size;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_size,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_size,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl_watchdog.sv
// Cycle counter that flags a bus access which has stayed outstanding too long.
// Only built when DMEM_TIMEOUT_EN is defined; otherwise this file is empty.
`ifdef DMEM_TIMEOUT_EN
module dmem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Count cycles spent waiting; cleared when a new access is launched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // The cycle being counted now is the TIMEOUT_CYCLES-th outstanding cycle.
  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/dmem_access_ctrl.sv
// M-stage data-memory access controller: launches each load/store on the
// bus, stalls F/D/E/M and bubbles MEM/WB until it completes, then opens a
// single DONE cycle so MEM/WB latches the finished instruction.
// Optional feature macro: DMEM_TIMEOUT_EN (watchdog abort after TIMEOUT_CYCLES).
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead_M,
  input  logic              memWrite_M,
  input  logic [1:0]        size_M,
  input  logic [31:0]       ALUResult_M,
  input  logic [31:0]       w_Data_M,
  dmem_bus_if.master        bus,
  output logic [31:0]       r_Data_M,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              stall_M,
  output logic              bubble_W,
  output logic              err_M,
  output state_e            state_dbg_o
);

  state_e      state_q;
  logic [31:0] r_data_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        err_q;

  logic access;
  logic misaligned;
  logic hold;
  logic timeout_hit;

  assign access     = memRead_M | memWrite_M;
  assign misaligned = is_misaligned(size_M, ALUResult_M[1:0]);

`ifdef DMEM_TIMEOUT_EN
  logic wd_clr;
  logic wd_en;

  // Restart the count whenever an aligned access is launched into REQ.
  assign wd_clr = (state_q == IDLE) && access && !misaligned;
  assign wd_en  = (state_q == REQ) || (state_q == RESP);

  dmem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (timeout_hit)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  // Access sequencer with registered bus outputs, load data and error pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      r_data_q <= 32'h0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      size_q   <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q  <= ALUResult_M;
              wdata_q <= w_Data_M;
              size_q  <= size_M;
              we_q    <= memWrite_M;
              req_q   <= 1'b1;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          // A handshake in the expiry cycle still completes normally.
          if (bus.dmem_ready) begin
            req_q   <= 1'b0;
            state_q <= we_q ? DONE : RESP;
          end else if (timeout_hit) begin
            req_q    <= 1'b0;
            r_data_q <= 32'h0;
            err_q    <= 1'b1;
            state_q  <= DONE;
          end
        end
        RESP: begin
          if (bus.dmem_rvalid) begin
            r_data_q <= bus.dmem_rdata;
            state_q  <= DONE;
          end else if (timeout_hit) begin
            r_data_q <= 32'h0;
            err_q    <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // Never launch from here: the next instruction arrives in M only
          // at this edge and is examined in IDLE.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Hold the front of the pipeline and bubble MEM/WB while an access is open.
  always_comb begin
    hold = 1'b0;
    case (state_q)
      IDLE:    hold = access;
      REQ:     hold = 1'b1;
      RESP:    hold = 1'b1;
      default: hold = 1'b0;
    endcase
  end

  assign stall_F  = hold;
  assign stall_D  = hold;
  assign stall_E  = hold;
  assign stall_M  = hold;
  assign bubble_W = hold;

  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.dmem_size  = size_q;

  assign r_Data_M    = r_data_q;
  assign err_M       = err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl; the timeout scenario is included when
// DMEM_TIMEOUT_EN is defined (the DUT is built with TIMEOUT_CYCLES=4).
module tb_dmem_access_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead_M, memWrite_M;
  logic [1:0]  size_M;
  logic [31:0] ALUResult_M, w_Data_M;
  logic [31:0] r_Data_M;
  logic        stall_F, stall_D, stall_E, stall_M, bubble_W, err_M;
  state_e      state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_bus_if bus ();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .memRead_M   (memRead_M),
    .memWrite_M  (memWrite_M),
    .size_M      (size_M),
    .ALUResult_M (ALUResult_M),
    .w_Data_M    (w_Data_M),
    .bus         (bus.master),
    .r_Data_M    (r_Data_M),
    .stall_F     (stall_F),
    .stall_D     (stall_D),
    .stall_E     (stall_E),
    .stall_M     (stall_M),
    .bubble_W    (bubble_W),
    .err_M       (err_M),
    .state_dbg_o (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All four stalls and bubble_W move together.
  task automatic chk_hold(input string tag, input logic exp);
    chk(tag, {27'd0, stall_F, stall_D, stall_E, stall_M, bubble_W}, exp ? 32'h1F : 32'h0);
  endtask

  task automatic chk_state(input string tag, input state_e exp);
    chk(tag, 32'(state_dbg), 32'(exp));
  endtask

  initial begin
    reset = 1'b0;
    memRead_M = 1'b0; memWrite_M = 1'b0; size_M = 2'd0;
    ALUResult_M = 32'h0; w_Data_M = 32'h0;
    bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;

    // ---- reset state ----
    tick(); tick();
    chk_state("rst_state", IDLE);
    chk("rst_req", {31'd0, bus.dmem_req}, 32'h0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_rdata", r_Data_M, 32'h0);
    chk("rst_err", {31'd0, err_M}, 32'h0);
    chk_hold("rst_hold", 1'b0);
    reset = 1'b1;

    // ---- non-memory instruction: no stall ----
    tick(); tick();
    chk_state("nomem_state", IDLE);
    chk_hold("nomem_hold", 1'b0);

    // ---- load word 0x100, ready immediate, rvalid one cycle later ----
    memRead_M = 1'b1; size_M = SIZE_W; ALUResult_M = 32'h100; bus.dmem_ready = 1'b1;
    #1 chk_hold("ld_idle_hold", 1'b1);
    tick();
    chk_state("ld_req_state", REQ);
    chk("ld_req", {31'd0, bus.dmem_req}, 32'h1);
    chk("ld_addr", bus.dmem_addr, 32'h100);
    chk("ld_we", {31'd0, bus.dmem_we}, 32'h0);
    chk("ld_size", {30'd0, bus.dmem_size}, 32'h2);
    chk_hold("ld_req_hold", 1'b1);
    tick();
    bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
    chk_state("ld_resp_state", RESP);
    chk("ld_resp_req", {31'd0, bus.dmem_req}, 32'h0);
    chk_hold("ld_resp_hold", 1'b1);
    tick();
    chk_state("ld_done_state", DONE);
    chk("ld_data", r_Data_M, 32'hCAFEF00D);
    chk_hold("ld_done_hold", 1'b0);
    chk("ld_done_err", {31'd0, err_M}, 32'h0);
    bus.dmem_rvalid = 1'b0; memRead_M = 1'b0;
    tick();
    chk_state("ld_after_state", IDLE);

    // ---- store half 0x202, ready low for 4 REQ cycles ----
    memWrite_M = 1'b1; size_M = SIZE_H; ALUResult_M = 32'h202; w_Data_M = 32'h1234ABCD;
    #1 chk_hold("st_idle_hold", 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.dmem_ready = 1'b1;
      chk("st_req", {31'd0, bus.dmem_req}, 32'h1);
      chk("st_addr", bus.dmem_addr, 32'h202);
      chk("st_wdata", bus.dmem_wdata, 32'h1234ABCD);
      chk("st_size", {30'd0, bus.dmem_size}, 32'h1);
      chk("st_we", {31'd0, bus.dmem_we}, 32'h1);
      chk_hold("st_req_hold", 1'b1);
      tick();
    end
    chk_state("st_done_state", DONE);
    chk("st_done_req", {31'd0, bus.dmem_req}, 32'h0);
    chk("st_rdata_kept", r_Data_M, 32'hCAFEF00D);
    chk_hold("st_done_hold", 1'b0);
    memWrite_M = 1'b0; bus.dmem_ready = 1'b0;
    tick();
    chk_state("st_after_state", IDLE);

    // ---- misaligned load word 0x103 ----
    memRead_M = 1'b1; size_M = SIZE_W; ALUResult_M = 32'h103;
    #1 chk_hold("mis_idle_hold", 1'b1);
    tick();
    chk_state("mis_done_state", DONE);
    chk("mis_err", {31'd0, err_M}, 32'h1);
    chk("mis_req", {31'd0, bus.dmem_req}, 32'h0);
    chk_hold("mis_done_hold", 1'b0);
    memRead_M = 1'b0;
    tick();
    chk("mis_err_pulse", {31'd0, err_M}, 32'h0);
    chk("mis_req2", {31'd0, bus.dmem_req}, 32'h0);
    chk("mis_rdata_kept", r_Data_M, 32'hCAFEF00D);

    // ---- size code 3 is treated as misaligned ----
    memRead_M = 1'b1; size_M = 2'd3; ALUResult_M = 32'h200;
    tick();
    chk("sz3_err", {31'd0, err_M}, 32'h1);
    chk("sz3_req", {31'd0, bus.dmem_req}, 32'h0);
    memRead_M = 1'b0;
    tick();

    // ---- two consecutive loads ----
    memRead_M = 1'b1; size_M = SIZE_W; ALUResult_M = 32'h40;
    bus.dmem_ready = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h11111111;
    tick(); chk_state("b2b1_req", REQ);
    tick(); chk_state("b2b1_resp", RESP);
    tick();
    chk_state("b2b1_done", DONE);
    chk("b2b1_data", r_Data_M, 32'h11111111);
    chk("b2b1_done_req", {31'd0, bus.dmem_req}, 32'h0);
    tick();
    ALUResult_M = 32'h44; bus.dmem_rdata = 32'h22222222;
    chk_state("b2b2_idle", IDLE);
    chk("b2b2_idle_req", {31'd0, bus.dmem_req}, 32'h0);
    #1 chk_hold("b2b2_idle_hold", 1'b1);
    tick();
    chk_state("b2b2_req", REQ);
    chk("b2b2_addr", bus.dmem_addr, 32'h44);
    tick(); tick();
    chk_state("b2b2_done", DONE);
    chk("b2b2_data", r_Data_M, 32'h22222222);
    memRead_M = 1'b0; bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0;
    tick();

    // ---- reset during RESP, then a late rvalid ----
    memRead_M = 1'b1; size_M = SIZE_W; ALUResult_M = 32'h80; bus.dmem_ready = 1'b1;
    tick(); tick();
    bus.dmem_ready = 1'b0;
    chk_state("rr_resp", RESP);
    reset = 1'b0;
    tick();
    chk_state("rr_state", IDLE);
    chk("rr_req", {31'd0, bus.dmem_req}, 32'h0);
    chk("rr_addr", bus.dmem_addr, 32'h0);
    chk("rr_wdata", bus.dmem_wdata, 32'h0);
    chk("rr_size", {30'd0, bus.dmem_size}, 32'h0);
    chk("rr_rdata", r_Data_M, 32'h0);
    chk("rr_err", {31'd0, err_M}, 32'h0);
    reset = 1'b1; memRead_M = 1'b0;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
    tick();
    chk_state("rr_late_state", IDLE);
    chk("rr_late_rdata", r_Data_M, 32'h0);
    bus.dmem_rvalid = 1'b0;
    tick();

`ifdef DMEM_TIMEOUT_EN
    // ---- timeout: preload data, then a load whose rvalid never comes ----
    memRead_M = 1'b1; size_M = SIZE_W; ALUResult_M = 32'h10;
    bus.dmem_ready = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h5A5A5A5A;
    tick(); tick(); tick();
    chk("to_pre_data", r_Data_M, 32'h5A5A5A5A);
    bus.dmem_rvalid = 1'b0;
    tick();
    ALUResult_M = 32'h20;
    tick(); chk_state("to_c1", REQ);
    bus.dmem_ready = 1'b0;
    tick(); chk_state("to_c2", RESP);
    tick(); chk_state("to_c3", RESP);
    tick(); chk_state("to_c4", RESP);
    chk("to_c4_err", {31'd0, err_M}, 32'h0);
    tick();
    chk_state("to_done", DONE);
    chk("to_err", {31'd0, err_M}, 32'h1);
    chk("to_rdata", r_Data_M, 32'h0);
    chk_hold("to_done_hold", 1'b0);
    memRead_M = 1'b0;
    tick();
    chk("to_err_pulse", {31'd0, err_M}, 32'h0);
    chk_state("to_idle", IDLE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences every data-memory load/store in the M stage over a ready/valid memory bus. Holds the F/D/E/M pipeline registers with stall outputs until the access finishes. While stalled, it drives bubble_W so the MEM/WB register captures a no-write bubble. Sits between the M-stage control signals and the data-memory bus, and supplies r_Data_M to the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+RESP before watchdog abort (only used with DMEM_TIMEOUT_EN); counter width = $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
memRead_M  in  1  M-stage instruction is a load
memWrite_M  in  1  M-stage instruction is a store
size_M  in  2  access size: 0=byte, 1=half, 2=word; 3 is illegal and treated as misaligned
ALUResult_M  in  32  effective address
w_Data_M  in  32  store data
dmem_req  out  1  bus request
dmem_we  out  1  1=store
dmem_addr  out  32  bus address
dmem_wdata  out  32  bus store data
dmem_size  out  2  bus size
dmem_ready  in  1  bus accepts request (handshake = dmem_req & dmem_ready)
dmem_rvalid  in  1  load data valid
dmem_rdata  in  32  load data
r_Data_M  out  32  captured load data, to MEM/WB
stall_F, stall_D, stall_E, stall_M  out  1 each  hold the respective pipeline register
bubble_W  out  1  force regWrite=0 into MEM/WB this cycle
err_M  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- States: IDLE, REQ, RESP, DONE.
- Reset (reset==0 at posedge): state=IDLE, r_Data_M=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_size=0, err_M=0, timeout counter=0.
- Reset mid-access abandons the transaction with no bus cleanup. The bus side tolerates a dropped request.
- IDLE:
  - access = memRead_M|memWrite_M.
  - If access and address is misaligned (half with addr[0]=1; word with addr[1:0]!=0; size 3): no bus request, err_M pulses next cycle, go DONE.
  - Else if access: register addr/wdata/size/we onto the dmem_* outputs, go REQ.
  - Stalls and bubble_W are asserted combinationally in IDLE whenever access is 1.
- REQ: dmem_req=1 and outputs stable until handshake. On handshake: store goes DONE, load goes RESP.
- RESP: wait for dmem_rvalid; rvalid is only honoured here. On rvalid: r_Data_M<=dmem_rdata, go DONE.
- DONE: all stalls and bubble_W=0 for exactly one cycle, so MEM/WB latches the completed instruction. Always returns to IDLE; a new access is never started from DONE.
- Stall and bubble_W = (IDLE & access) | REQ | RESP. All four stalls are identical.
- Minimum latency:
  - Load with ready and rvalid each asserted immediately: 3 stall cycles, then 1 DONE cycle.
  - Store: 2 stall cycles, then DONE.
- Back-to-back accesses: the next instruction enters M at the DONE→IDLE edge and is detected in IDLE on the following cycle.
- r_Data_M holds its last value until the next load capture. It is not changed by stores.
- Non-memory instructions: state stays IDLE, no stall.

Optional Feature:
DMEM_TIMEOUT_EN
- Defined:
  - Counter clears on entering REQ and increments each cycle in REQ/RESP.
  - When the count reaches TIMEOUT_CYCLES: dmem_req drops, r_Data_M<=32'h0, err_M pulses, go DONE.
  - A handshake or rvalid in the same cycle as the limit wins over the timeout.
- Undefined: no counter; the controller waits indefinitely in REQ/RESP.

Decomposition:
- Package dmem_ctrl_pkg: state enum (IDLE/REQ/RESP/DONE), size localparams SIZE_B/SIZE_H/SIZE_W, misaligned-check function.
- One sub-module, dmem_watchdog: counter with clear/enable/expire, instantiated only under DMEM_TIMEOUT_EN.

Test Plan:
- Load word, addr 0x100, ready immediate, rvalid 1 cycle later with 0xCAFEF00D → stall high 3 cycles, bubble_W high same cycles, r_Data_M=0xCAFEF00D in DONE, stalls low in DONE.
- Store half, addr 0x202, ready held low 4 cycles → dmem_req held 5 cycles with addr/wdata/size stable, then DONE, no r_Data_M change.
- Load word, addr 0x103 → no dmem_req ever, err_M pulses once, one stall cycle, then DONE.
- Two consecutive loads → second request starts only after a DONE then IDLE cycle; each load's data is captured correctly.
- Reset asserted (0) during RESP → next cycle IDLE, all outputs at reset values, a late rvalid is ignored.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load where rvalid never comes → abort after 4 REQ+RESP cycles, err_M=1 for one cycle, r_Data_M=0.
